// File: rtl/i2s_tx_param.sv
// i2s_tx_param: I2S master generating MCLK/SCLK/LRCLK from clk and serialising stereo PCM.
// Define I2S_UNDERFLOW_HOLD_EN to repeat the last pair on underflow instead of sending silence.
module i2s_tx_param #(
   parameter int MCLK_DIV      = 10,
   parameter int MCLK_TO_LRCLK = 512,
   parameter int SAMPLE_BITS   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [SAMPLE_BITS-1:0] sample_left,
   input  logic [SAMPLE_BITS-1:0] sample_right,
   input  logic                   sample_valid,
   output logic                   sample_ready,
   output logic                   mclk,
   output logic                   sclk,
   output logic                   lrclk,
   output logic                   sdata,
   output logic                   underflow
);

   localparam int FW        = 2 * SAMPLE_BITS;
   localparam int SCLK_DIV  = MCLK_TO_LRCLK / FW;
   localparam int HALF_M    = MCLK_DIV / 2;
   localparam int SCLK_HALF = MCLK_DIV * SCLK_DIV / 2;
   localparam int MW        = (HALF_M > 1) ? $clog2(HALF_M) : 1;
   localparam int PW        = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
   localparam int SW        = $clog2(FW);

   if (MCLK_DIV < 2 || (MCLK_DIV % 2) != 0) begin : g_chk_mclk_div
      $error("i2s_tx_param: MCLK_DIV must be even and >= 2");
   end
   if (SAMPLE_BITS < 8 || SAMPLE_BITS > 32) begin : g_chk_sample_bits
      $error("i2s_tx_param: SAMPLE_BITS must be in 8..32");
   end
   if ((MCLK_TO_LRCLK % FW) != 0 || SCLK_DIV < 1) begin : g_chk_sclk_div
      $error("i2s_tx_param: MCLK_TO_LRCLK must be a multiple of 2*SAMPLE_BITS");
   end
   // An odd SCLK_DIV would put every other sclk edge on an mclk falling edge.
   if ((SCLK_DIV % 2) != 0) begin : g_chk_sclk_align
      $error("i2s_tx_param: SCLK_DIV must be even to keep sclk edges on mclk rising edges");
   end

   logic [MW-1:0] mcnt;
   logic [PW-1:0] pcnt;
   logic [SW-1:0] slot;
   logic [FW-1:0] buffer;
   logic [FW-1:0] shreg;
   logic          sclk_tick;
   logic          fall;
   logic          frame_start;
   logic          accept;

   always_comb begin
      sclk_tick   = (pcnt == PW'(HALF_M - 1));
      fall        = sclk_tick && sclk;
      frame_start = fall && (slot == '0);
      accept      = sample_valid && sample_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcnt <= '0;
         mclk <= 1'b0;
      end else if (mcnt == MW'(HALF_M - 1)) begin
         mcnt <= '0;
         mclk <= ~mclk;
      end else begin
         mcnt <= mcnt + 1'b1;
      end
   end

   // pcnt spans one sclk half-period; ticking at HALF_M-1 lands on mclk rising edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcnt <= '0;
         sclk <= 1'b0;
      end else begin
         pcnt <= (pcnt == PW'(SCLK_HALF - 1)) ? '0 : pcnt + 1'b1;
         if (sclk_tick) sclk <= ~sclk;
      end
   end

   // Rotating shifter: slot k emits original bit FW-k, slot 0 re-emits bit 0 of the prior frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot  <= '0;
         lrclk <= 1'b1;
         sdata <= 1'b0;
         shreg <= '0;
      end else if (fall) begin
         sdata <= shreg[FW-1];
         slot  <= (slot == SW'(FW - 1)) ? '0 : slot + 1'b1;
         if (slot == '0) lrclk <= 1'b0;
         else if (slot == SW'(SAMPLE_BITS)) lrclk <= 1'b1;
         if (frame_start && !sample_ready) shreg <= buffer;
`ifdef I2S_UNDERFLOW_HOLD_EN
         else shreg <= {shreg[FW-2:0], shreg[FW-1]};
`else
         else if (frame_start) shreg <= '0;
         else shreg <= {shreg[FW-2:0], shreg[FW-1]};
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buffer       <= '0;
         sample_ready <= 1'b1;
         underflow    <= 1'b0;
      end else begin
         underflow <= frame_start && sample_ready;
         if (accept) begin
            buffer       <= {sample_left, sample_right};
            sample_ready <= 1'b0;
         end else if (frame_start) begin
            sample_ready <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx_param.sv
// tb_i2s_tx_param: directed bench with a cycle model of the clocks/handshake and a frame scoreboard.
module tb_i2s_tx_param;

   localparam int MD    = 4;
   localparam int M2L   = 64;
   localparam int SB    = 16;
   localparam int FW    = 2 * SB;
   localparam int HM    = MD / 2;
   localparam int SH    = MD * (M2L / FW) / 2;
   localparam int FRAME = MD * M2L;
   localparam int FS0   = HM + SH;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [SB-1:0] sample_left = '0;
   logic [SB-1:0] sample_right = '0;
   logic          sample_valid = 1'b0;
   logic          sample_ready, mclk, sclk, lrclk, sdata, underflow;

   i2s_tx_param #(.MCLK_DIV(MD), .MCLK_TO_LRCLK(M2L), .SAMPLE_BITS(SB)) dut (
      .clk(clk), .rst(rst), .sample_left(sample_left), .sample_right(sample_right),
      .sample_valid(sample_valid), .sample_ready(sample_ready), .mclk(mclk), .sclk(sclk),
      .lrclk(lrclk), .sdata(sdata), .underflow(underflow)
   );

   initial forever #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // model state: cyc = clk edges since reset release
   int            cyc = 0;
   bit            m_ready = 1'b1;
   bit            m_uf = 1'b0;
   logic [FW-1:0] m_buf = '0;
   logic [FW-1:0] m_last = '0;
   logic [FW-1:0] exp_q[$];
   bit            mon_prev = 1'b0;
   bit            mon_lr = 1'b1;
   bit            mon_started = 1'b0;
   int            mon_cnt = 0;
   logic [FW-1:0] mon_sh = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic bit exp_mclk(input int e);
      return ((e / HM) % 2) == 1;
   endfunction

   function automatic bit exp_sclk(input int e);
      if (e < HM) return 1'b0;
      return (((e - HM) / SH + 1) % 2) == 1;
   endfunction

   function automatic bit exp_lrclk(input int e);
      if (e < FS0) return 1'b1;
      return ((e - FS0) % FRAME) >= FRAME / 2;
   endfunction

   function automatic bit is_fs(input int e);
      return (e >= FS0) && (((e - FS0) % FRAME) == 0);
   endfunction

   // Outputs are checked mid-cycle; then the model advances over the coming edge
   initial begin
      int            e;
      bit            acc;
      bit            fs;
      logic [FW-1:0] exp_frame;
      forever begin
         @(negedge clk);
         if (rst) begin
            cyc = 0; m_ready = 1'b1; m_uf = 1'b0; m_buf = '0; m_last = '0;
            exp_q.delete();
            mon_prev = 1'b0; mon_lr = 1'b1; mon_started = 1'b0; mon_cnt = 0; mon_sh = '0;
         end else begin
            check("mclk", mclk, exp_mclk(cyc));
            check("sclk", sclk, exp_sclk(cyc));
            check("lrclk", lrclk, exp_lrclk(cyc));
            check("sample_ready", sample_ready, m_ready);
            check("underflow", underflow, m_uf);
            if (sclk === 1'b1 && mon_prev == 1'b0) begin
               mon_sh = {mon_sh[FW-2:0], sdata};
               if (lrclk === 1'b0 && mon_lr) begin
                  if (mon_started) begin
                     check("frame_len", mon_cnt, FW - 1);
                     check("exp_available", exp_q.size() > 0, 1'b1);
                     if (exp_q.size() > 0) begin
                        exp_frame = exp_q.pop_front();
                        check("frame_data", mon_sh, exp_frame);
                     end
                  end
                  mon_started = 1'b1;
                  mon_cnt = 0;
               end else begin
                  mon_cnt++;
               end
               mon_lr = (lrclk === 1'b1);
            end
            mon_prev = (sclk === 1'b1);

            e   = cyc + 1;
            fs  = is_fs(e);
            acc = (sample_valid === 1'b1) && m_ready;
            m_uf = fs && m_ready;
            if (fs) begin
               if (!m_ready) begin
                  exp_q.push_back(m_buf);
                  m_last = m_buf;
               end else begin
`ifdef I2S_UNDERFLOW_HOLD_EN
                  exp_q.push_back(m_last);
`else
                  exp_q.push_back('0);
`endif
               end
            end
            if (acc) begin
               m_buf = {sample_left, sample_right};
               m_ready = 1'b0;
            end else if (fs) begin
               m_ready = 1'b1;
            end
            cyc = e;
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Holds valid until the DUT accepts, then drops it just after the accepting edge
   task automatic send_pair(input logic [SB-1:0] l, input logic [SB-1:0] r);
      bit done = 1'b0;
      sample_left  = l;
      sample_right = r;
      sample_valid = 1'b1;
      for (int i = 0; i < 2 * FRAME && !done; i++) begin
         @(negedge clk);
         if (sample_ready === 1'b1) done = 1'b1;
         @(posedge clk);
         #1;
      end
      sample_valid = 1'b0;
      check("accept_in_time", done, 1'b1);
   endtask

   task automatic check_reset();
      check("rst_mclk", mclk, 1'b0);
      check("rst_sclk", sclk, 1'b0);
      check("rst_lrclk", lrclk, 1'b1);
      check("rst_sdata", sdata, 1'b0);
      check("rst_underflow", underflow, 1'b0);
      check("rst_ready", sample_ready, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit hit;
      repeat (3) @(posedge clk);
      #1;
      check_reset();
      rst = 1'b0;

      // first frame underflows; then serial pattern twice, then underflow after 1234/5678
      send_pair(16'hA5C3, 16'h0F0F);
      send_pair(16'hA5C3, 16'h0F0F);
      send_pair(16'h1234, 16'h5678);
      wait_cycles(4 * FRAME);

      // back-to-back stream of distinct pairs
      for (int i = 0; i < 8; i++) begin
         send_pair({8'(i + 1), 8'($urandom)}, {8'($urandom), 8'(8'hF0 - i)});
      end
      wait_cycles(3 * FRAME);

      // accept in the exact frame-start cycle with the buffer empty
      hit = 1'b0;
      for (int i = 0; i < 2 * FRAME && !hit; i++) begin
         @(posedge clk);
         #1;
         if (is_fs(cyc + 1)) hit = 1'b1;
      end
      check("fs_found", hit, 1'b1);
      sample_left  = 16'hBEEF;
      sample_right = 16'h1357;
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      check("simul_underflow", underflow, 1'b1);
      check("simul_ready", sample_ready, 1'b0);
      wait_cycles(3 * FRAME);

      // asynchronous reset mid-frame, then a preloaded pair avoids the first underflow
      wait_cycles(101);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      send_pair(16'h8001, 16'h7FFE);
      wait_cycles(3 * FRAME);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
